// File: rtl/fibonacci.sv
// Fibonacci bus master: reads a {a, b, c, k} record from memory, runs k
// Fibonacci steps on (a, b), then writes back {a, b, b, 0}.
// Every bus request is held until ready, and valid is low for at least one
// cycle between requests.
module fibonacci (
   input  logic        clk,
   input  logic        rstb,
   input  logic        setb,
   output logic        idle,
   input  logic [31:0] a00,
   input  logic [31:0] ra0,
   input  logic [31:0] a40,
   input  logic [31:0] a50,
   input  logic [7:0]  pc0,
   input  logic [31:0] sp0,
   output logic [31:0] addr,
   output logic [2:0]  size,
   output logic        valid,
   output logic        write,
   output logic [31:0] wdata,
   input  logic [31:0] rdata,
   input  logic        ready
);

   typedef enum logic [3:0] {
      ST_LOAD = 4'd0,
      ST_RD_A = 4'd1,
      ST_RD_B = 4'd2,
      ST_RD_K = 4'd3,
      ST_ITER = 4'd4,
      ST_WR_A = 4'd5,
      ST_WR_B = 4'd6,
      ST_WR_C = 4'd7,
      ST_WR_K = 4'd8,
      ST_DONE = 4'd9
   } state_t;

   state_t      state_r, state_s, succ_s;
   logic        valid_r, valid_s, write_r, write_s, idle_r, idle_s;
   logic [2:0]  size_r;
   logic [31:0] addr_r, addr_s, wdata_r, wdata_s;
   logic [31:0] a_r, a_s, b_r, b_s, k_r, k_s;
   logic [31:0] base_r, ra_r, a4_r, a5_r, sp_r;
   logic [7:0]  pc_r;
   logic        bus_st_s, req_wr_s;
   logic [31:0] req_off_s, req_data_s;

   assign addr  = addr_r;
   assign size  = size_r;
   assign valid = valid_r;
   assign write = write_r;
   assign wdata = wdata_r;
   assign idle  = idle_r;

   // Request descriptor (offset, direction, data, follow-on state) of each bus state
   always_comb begin
      bus_st_s   = 1'b1;
      req_off_s  = 32'd0;
      req_wr_s   = 1'b0;
      req_data_s = 32'd0;
      succ_s     = ST_LOAD;
      case (state_r)
         ST_RD_A: begin req_off_s = 32'd0;  succ_s = ST_RD_B; end
         ST_RD_B: begin req_off_s = 32'd4;  succ_s = ST_RD_K; end
         ST_RD_K: begin req_off_s = 32'd12; succ_s = ST_ITER; end
         ST_WR_A: begin req_off_s = 32'd0;  req_wr_s = 1'b1; req_data_s = a_r; succ_s = ST_WR_B; end
         ST_WR_B: begin req_off_s = 32'd4;  req_wr_s = 1'b1; req_data_s = b_r; succ_s = ST_WR_C; end
         ST_WR_C: begin req_off_s = 32'd8;  req_wr_s = 1'b1; req_data_s = b_r; succ_s = ST_WR_K; end
         ST_WR_K: begin req_off_s = 32'd12; req_wr_s = 1'b1; req_data_s = 32'd0; succ_s = ST_DONE; end
         default: bus_st_s = 1'b0;
      endcase
   end

   // Next state, next bus outputs and next arithmetic registers
   always_comb begin
      state_s = state_r;
      valid_s = valid_r;
      write_s = write_r;
      addr_s  = addr_r;
      wdata_s = wdata_r;
      a_s     = a_r;
      b_s     = b_r;
      k_s     = k_r;
      case (state_r)
         ST_LOAD: begin
            valid_s = 1'b0;
            if (setb) state_s = ST_RD_A;
            else      state_s = ST_LOAD;
         end
         ST_ITER: begin
            if (!setb) begin
               state_s = ST_LOAD;
            end else if (k_r != 32'd0) begin
               a_s = b_r;
               b_s = a_r + b_r;
               k_s = k_r - 32'd1;
            end else begin
               state_s = ST_WR_A;
            end
         end
         ST_DONE: begin
            valid_s = 1'b0;
            if (setb) state_s = ST_DONE;
            else      state_s = ST_LOAD;
         end
         default: begin
            if (!bus_st_s) begin
               // unreachable encodings recover to LOAD
               valid_s = 1'b0;
               state_s = ST_LOAD;
            end else if (valid_r) begin
               if (ready) begin
                  // completing edge: drop valid, capture read data, move on
                  valid_s = 1'b0;
                  state_s = succ_s;
                  case (state_r)
                     ST_RD_A: a_s = rdata;
                     ST_RD_B: b_s = rdata;
                     ST_RD_K: k_s = rdata;
                     default: a_s = a_r;
                  endcase
               end else begin
                  valid_s = 1'b1;
               end
            end else if (!setb) begin
               // abort only between transactions
               state_s = ST_LOAD;
            end else begin
               valid_s = 1'b1;
               addr_s  = base_r + req_off_s;
               write_s = req_wr_s;
               wdata_s = req_data_s;
            end
         end
      endcase
      idle_s = (state_s == ST_DONE) ? 1'b1 : 1'b0;
   end

   // State register
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state_r <= ST_LOAD;
      else       state_r <= state_s;
   end

   // Registered bus outputs, idle flag and Fibonacci working registers
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         valid_r <= 1'b0;
         write_r <= 1'b0;
         idle_r  <= 1'b0;
         size_r  <= 3'd2;
         addr_r  <= 32'd0;
         wdata_r <= 32'd0;
         a_r     <= 32'd0;
         b_r     <= 32'd0;
         k_r     <= 32'd0;
      end else begin
         valid_r <= valid_s;
         write_r <= write_s;
         idle_r  <= idle_s;
         size_r  <= 3'd2;
         addr_r  <= addr_s;
         wdata_r <= wdata_s;
         a_r     <= a_s;
         b_r     <= b_s;
         k_r     <= k_s;
      end
   end

   // Continuous capture of the start-up context while in LOAD
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         base_r <= 32'd0;
         ra_r   <= 32'd0;
         a4_r   <= 32'd0;
         a5_r   <= 32'd0;
         sp_r   <= 32'd0;
         pc_r   <= 8'd0;
      end else if (state_r == ST_LOAD) begin
         base_r <= a00;
         ra_r   <= ra0;
         a4_r   <= a40;
         a5_r   <= a50;
         sp_r   <= sp0;
         pc_r   <= pc0;
      end
   end

endmodule

// File: tb/tb_fibonacci.sv
// Self-checking bench for fibonacci: memory responder, bus protocol
// checks and a plain-arithmetic Fibonacci reference model.
module tb_fibonacci;

   logic        clk = 1'b0;
   logic        rstb, setb, idle, valid, write, ready;
   logic [31:0] a00, ra0, a40, a50, sp0, addr, wdata, rdata;
   logic [7:0]  pc0;
   logic [2:0]  size;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:3];
   logic [31:0] base_q;
   int          n_rd, n_wr;
   bit          rnd_ready;
   logic        p_valid, p_cpl, p_write;
   logic [31:0] p_addr, p_wdata;

   always #5 clk = ~clk;

   fibonacci dut (
      .clk(clk), .rstb(rstb), .setb(setb), .idle(idle),
      .a00(a00), .ra0(ra0), .a40(a40), .a50(a50), .pc0(pc0), .sp0(sp0),
      .addr(addr), .size(size), .valid(valid), .write(write),
      .wdata(wdata), .rdata(rdata), .ready(ready)
   );

   // reference: k Fibonacci steps on (a, b), 32-bit wrap
   task automatic ref_model(input logic [31:0] a, b, k, output logic [31:0] fa, fb);
      logic [31:0] t;
      fa = a;
      fb = b;
      for (longint i = 0; i < longint'(k); i++) begin
         t  = fa + fb;
         fa = fb;
         fb = t;
      end
   endtask

   // one low phase: protocol checks on the request, then respond for the next edge
   task automatic bus_step();
      logic cpl;
      int   idx;
      if (valid) begin
         checks++;
         if (size !== 3'd2) begin errors++; $display("FAIL size got %0d want 2", size); end
         checks++;
         if (addr < base_q || addr > base_q + 32'd12 || addr[1:0] != 2'b00) begin
            errors++; $display("FAIL addr_range got %h base %h", addr, base_q);
         end
      end
      if (p_valid && !p_cpl) begin
         checks++;
         if (valid !== 1'b1 || addr !== p_addr || write !== p_write || (p_write && wdata !== p_wdata)) begin
            errors++;
            $display("FAIL req_stable got v=%b a=%h w=%b d=%h want v=1 a=%h w=%b d=%h",
                     valid, addr, write, wdata, p_addr, p_write, p_wdata);
         end
      end
      if (p_cpl) begin
         checks++;
         if (valid !== 1'b0) begin errors++; $display("FAIL valid_gap got %b want 0", valid); end
      end
      if (valid && !p_valid) begin
         if (write) n_wr++;
         else       n_rd++;
      end
      if (rnd_ready) ready = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
      else           ready = p_valid;  // ready is valid delayed by one clock
      cpl = valid && ready;
      idx = int'((addr - base_q) >> 2);
      if (idx < 0 || idx > 3) idx = 0;
      if (cpl && !write) rdata = mem[idx];
      else               rdata = $urandom;
      if (cpl && write) mem[idx] = wdata;
      p_valid = valid;
      p_cpl   = cpl;
      p_addr  = addr;
      p_write = write;
      p_wdata = wdata;
   endtask

   task automatic start_job(input logic [31:0] base, ia, ib, ic, ik, input bit rr);
      mem[0] = ia; mem[1] = ib; mem[2] = ic; mem[3] = ik;
      base_q = base;
      a00 = base;
      ra0 = $urandom; a40 = $urandom; a50 = $urandom; sp0 = $urandom;
      pc0 = 8'($urandom);
      rnd_ready = rr;
      n_rd = 0; n_wr = 0;
      p_valid = 1'b0; p_cpl = 1'b0;
      setb = 1'b1;
   endtask

   task automatic run_job(input string name, input logic [31:0] base, ia, ib, ic, ik, input bit rr);
      logic [31:0] ea, eb;
      bit          seen;
      ref_model(ia, ib, ik, ea, eb);
      start_job(base, ia, ib, ic, ik, rr);
      seen = 1'b0;
      for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
         @(negedge clk);
         bus_step();
         if (idle === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL %s idle_timeout got idle=%b want 1", name, idle); end
      checks++;
      if (mem[0] !== ea) begin errors++; $display("FAIL %s mem_a got %0d want %0d", name, mem[0], ea); end
      checks++;
      if (mem[1] !== eb) begin errors++; $display("FAIL %s mem_b got %0d want %0d", name, mem[1], eb); end
      checks++;
      if (mem[2] !== eb) begin errors++; $display("FAIL %s mem_c got %0d want %0d", name, mem[2], eb); end
      checks++;
      if (mem[3] !== 32'd0) begin errors++; $display("FAIL %s mem_k got %0d want 0", name, mem[3]); end
      checks++;
      if (n_rd != 3 || n_wr != 4) begin
         errors++; $display("FAIL %s txn_count got rd=%0d wr=%0d want rd=3 wr=4", name, n_rd, n_wr);
      end
      // DONE holds while setb stays high
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus_step();
      end
      checks++;
      if (idle !== 1'b1 || valid !== 1'b0) begin
         errors++; $display("FAIL %s done_hold got idle=%b valid=%b want 1 0", name, idle, valid);
      end
      setb = 1'b0;
      @(negedge clk);
      bus_step();
      checks++;
      if (idle !== 1'b0) begin errors++; $display("FAIL %s idle_drop got %b want 0", name, idle); end
   endtask

   task automatic test_reset();
      rstb = 1'b0; setb = 1'b0; ready = 1'b0; rdata = 32'd0;
      a00 = 32'd0; ra0 = 32'd0; a40 = 32'd0; a50 = 32'd0; sp0 = 32'd0; pc0 = 8'd0;
      base_q = 32'd0; p_valid = 1'b0; p_cpl = 1'b0;
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || idle !== 1'b0 || write !== 1'b0) begin
         errors++; $display("FAIL reset_flags got v=%b i=%b w=%b want 0 0 0", valid, idle, write);
      end
      checks++;
      if (addr !== 32'd0 || wdata !== 32'd0) begin
         errors++; $display("FAIL reset_bus got addr=%h wdata=%h want 0 0", addr, wdata);
      end
      checks++;
      if (size !== 3'd2) begin errors++; $display("FAIL reset_size got %0d want 2", size); end
      rstb = 1'b1;
      for (int i = 0; i < 4; i++) @(negedge clk);
      checks++;
      if (valid !== 1'b0 || idle !== 1'b0) begin
         errors++; $display("FAIL load_hold got v=%b i=%b want 0 0", valid, idle);
      end
   endtask

   task automatic test_directed();
      run_job("fib16", 32'h0000_1000, 32'd1, 32'd1, 32'd0, 32'd16, 1'b0);
      checks++;
      if (mem[0] !== 32'd1597 || mem[1] !== 32'd2584) begin
         errors++; $display("FAIL fib16_const got a=%0d b=%0d want 1597 2584", mem[0], mem[1]);
      end
      run_job("k1", 32'h0000_1000, 32'd1, 32'd1, 32'd0, 32'd1, 1'b0);
      run_job("k0", 32'h0000_1000, 32'd5, 32'd7, 32'd99, 32'd0, 1'b0);
      run_job("k47", 32'h0000_1000, 32'd1, 32'd1, 32'd0, 32'd47, 1'b1);
      checks++;
      if (mem[1] !== 32'd3483774753 || mem[2] !== 32'd3483774753) begin
         errors++; $display("FAIL k47_const got b=%0d c=%0d want 3483774753", mem[1], mem[2]);
      end
   endtask

   task automatic test_random();
      logic [31:0] base;
      for (int j = 0; j < 6; j++) begin
         base = 32'h0001_0000 + (32'($urandom_range(0, 255)) << 4);
         run_job("random", base, $urandom, $urandom, $urandom, 32'($urandom_range(0, 40)), 1'b1);
      end
   endtask

   task automatic test_abort();
      bit found;
      int cnt;
      start_job(32'h0000_3000, 32'd2, 32'd3, 32'd0, 32'd40, 1'b1);
      found = 1'b0;
      for (int cyc = 0; cyc < 500 && !found; cyc++) begin
         @(negedge clk);
         bus_step();
         if (valid && !write && n_rd >= 2) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL abort_setup got no read request want one"); end
      setb = 1'b0;
      cnt = n_rd + n_wr;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus_step();
      end
      checks++;
      if (valid !== 1'b0 || idle !== 1'b0 || n_rd + n_wr != cnt) begin
         errors++;
         $display("FAIL abort got v=%b i=%b reqs=%0d want 0 0 %0d", valid, idle, n_rd + n_wr, cnt);
      end
      run_job("after_abort", 32'h0000_3000, 32'd2, 32'd3, 32'd0, 32'd10, 1'b1);
   endtask

   task automatic test_reset_mid();
      bit found;
      start_job(32'h0000_2000, 32'd1, 32'd1, 32'd0, 32'd30, 1'b0);
      found = 1'b0;
      for (int cyc = 0; cyc < 200 && !found; cyc++) begin
         @(negedge clk);
         bus_step();
         if (valid === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL rst_mid_setup got no request want one"); end
      #2 rstb = 1'b0;
      #1;
      checks++;
      if (valid !== 1'b0 || idle !== 1'b0) begin
         errors++; $display("FAIL rst_mid got v=%b i=%b want 0 0", valid, idle);
      end
      ready = 1'b0;
      setb  = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);
      run_job("after_reset", 32'h0000_2000, 32'd1, 32'd1, 32'd0, 32'd30, 1'b1);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
